// File: rtl/decode_issue.sv
// Decode/issue stage: small in-order instruction queue, register file with
// writeback bypass, and a busy scoreboard that stalls dispatch on RAW/WAW hazards.
module decode_issue #(
  parameter  int DATA_W    = 16,
  parameter  int NREGS     = 8,
  parameter  int DEPTH     = 2,
  parameter  int PAYLOAD_W = 32,
  localparam int RSEL_W    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [PAYLOAD_W-1:0] enq_payload,
  input  logic [RSEL_W-1:0]    enq_rx,
  input  logic [RSEL_W-1:0]    enq_ry,
  input  logic [RSEL_W-1:0]    enq_ro,
  input  logic                 enq_use_x,
  input  logic                 enq_use_y,
  input  logic                 enq_wen,
  input  logic                 flush,
  input  logic                 wb_wen,
  input  logic [RSEL_W-1:0]    wb_rsel,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [DATA_W-1:0]    iss_vx,
  output logic [DATA_W-1:0]    iss_vy,
  output logic [RSEL_W-1:0]    iss_ro,
  output logic                 iss_wen,
  output logic                 err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [RSEL_W-1:0]    rx;
    logic [RSEL_W-1:0]    ry;
    logic [RSEL_W-1:0]    ro;
    logic                 use_x;
    logic                 use_y;
    logic                 wen;
  } entry_t;

  entry_t               q_mem_q [DEPTH];
  entry_t               q_mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NREGS-1:0]     busy_q, busy_d;
  logic [DATA_W-1:0]    rf_q [NREGS];
  logic [DATA_W-1:0]    rf_d [NREGS];
  logic                 iss_valid_q, iss_valid_d;
  logic [PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
  logic [DATA_W-1:0]    iss_vx_q, iss_vx_d;
  logic [DATA_W-1:0]    iss_vy_q, iss_vy_d;
  logic [RSEL_W-1:0]    iss_ro_q, iss_ro_d;
  logic                 iss_wen_q, iss_wen_d;
  logic                 err_q, err_d;

  logic [NREGS-1:0]     wb_hit;
  logic [NREGS-1:0]     busy_eff;
  entry_t               enq_entry;
  entry_t               head;
  logic                 full, empty, enq_fire, hazard, dispatch;

  assign enq_entry = {enq_payload, enq_rx, enq_ry, enq_ro, enq_use_x, enq_use_y, enq_wen};
  assign head      = q_mem_q[rd_ptr_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ready = !full && !flush;
  assign enq_fire  = enq_valid && enq_ready;

  // A writeback landing this cycle already counts as "not busy" for the hazard check.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      assign wb_hit[gi]   = wb_wen && (wb_rsel == RSEL_W'(gi));
      assign busy_eff[gi] = busy_q[gi] && !wb_hit[gi];
      assign busy_d[gi]   = (dispatch && head.wen && (head.ro == RSEL_W'(gi))) || busy_eff[gi];
      assign rf_d[gi]     = wb_hit[gi] ? wb_data : rf_q[gi];
    end
  endgenerate

  assign hazard = (head.use_x && busy_eff[head.rx]) ||
                  (head.use_y && busy_eff[head.ry]) ||
                  (head.wen   && busy_eff[head.ro]);

  assign dispatch = !empty && (!iss_valid_q || iss_ready) && !hazard && !flush;

  function automatic logic [DATA_W-1:0] read_bypass(input logic [RSEL_W-1:0] sel);
    return (wb_wen && (wb_rsel == sel)) ? wb_data : rf_q[sel];
  endfunction

  always_comb begin
    q_mem_d  = q_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        q_mem_d[wr_ptr_q] = enq_entry;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (dispatch) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(dispatch);
    end
  end

  always_comb begin
    iss_valid_d   = iss_valid_q;
    iss_payload_d = iss_payload_q;
    iss_vx_d      = iss_vx_q;
    iss_vy_d      = iss_vy_q;
    iss_ro_d      = iss_ro_q;
    iss_wen_d     = iss_wen_q;
    if (flush) begin
      iss_valid_d = 1'b0;
    end else if (dispatch) begin
      iss_valid_d   = 1'b1;
      iss_payload_d = head.payload;
      iss_vx_d      = read_bypass(head.rx);
      iss_vy_d      = read_bypass(head.ry);
      iss_ro_d      = head.ro;
      iss_wen_d     = head.wen;
    end else if (iss_ready) begin
      iss_valid_d = 1'b0;
    end
  end

  // A writeback to a register nobody is waiting on means the pipeline lost track.
  assign err_d = err_q || (wb_wen && !busy_q[wb_rsel]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q_mem_q[i] <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      busy_q        <= '0;
      iss_valid_q   <= 1'b0;
      iss_payload_q <= '0;
      iss_vx_q      <= '0;
      iss_vy_q      <= '0;
      iss_ro_q      <= '0;
      iss_wen_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      q_mem_q       <= q_mem_d;
      rf_q          <= rf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      iss_valid_q   <= iss_valid_d;
      iss_payload_q <= iss_payload_d;
      iss_vx_q      <= iss_vx_d;
      iss_vy_q      <= iss_vy_d;
      iss_ro_q      <= iss_ro_d;
      iss_wen_q     <= iss_wen_d;
      err_q         <= err_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_payload = iss_payload_q;
  assign iss_vx      = iss_vx_q;
  assign iss_vy      = iss_vy_q;
  assign iss_ro      = iss_ro_q;
  assign iss_wen     = iss_wen_q;
  assign err         = err_q;

endmodule
